// File: rtl/serial_pkg.sv
// Shared serial-line definitions used by the transmitter and the future receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic TXD_IDLE = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Word-load handshake plus serial line of the transmitter.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Data;
    logic              Load;
    logic              Ready;
    logic              TxD;
    logic              Busy;

    modport master (output Data, output Load, input Ready, input TxD, input Busy);
    modport slave  (input Data, input Load, output Ready, output TxD, output Busy);
endinterface

// File: rtl/bit_timer.sv
// Bit-period counter: runs 0..BIT_CYCLES-1 while enabled, ticks on the last count.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic CLK,
    input  logic Clr,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (Clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic       CLK,
    input  logic       Clr,
    serial_tx_if.slave bus
);
    localparam int IW = $clog2(DATA_W + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              rdy_q, rdy_d;
    logic              busy_q;
    logic              tick;

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .CLK    (CLK),
        .Clr    (Clr),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    // The line level for each bit is registered on the edge that enters its period.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        par_d   = par_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = TXD_IDLE;
                if (bus.Load && rdy_q) begin
                    state_d = START;
                    sh_d    = bus.Data;
                    par_d   = ^bus.Data;
                    idx_d   = '0;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    idx_d   = IW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == IW'(DATA_W)) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    txd_d   = TXD_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = TXD_IDLE;
            end
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (Clr) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= TXD_IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            rdy_q   <= rdy_d;
            busy_q  <= ~rdy_d;
        end
    end

    assign bus.TxD   = txd_q;
    assign bus.Ready = rdy_q;
    assign bus.Busy  = busy_q;
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance without parity, one with; expected bits come from a scoreboard queue.
module tb_serial_tx;
    localparam int DW = 8;
    localparam int BC = 4;

    logic CLK = 1'b0;
    logic Clr;
    always #5 CLK = ~CLK;

    serial_tx_if #(.DATA_W(DW)) if0 ();
    serial_tx_if #(.DATA_W(DW)) if1 ();

    serial_tx #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_EN(0)) dut0 (
        .CLK (CLK),
        .Clr (Clr),
        .bus (if0.slave)
    );
    serial_tx #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_EN(1)) dut1 (
        .CLK (CLK),
        .Clr (Clr),
        .bus (if1.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit exp_q[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txd(int s);
        return (s != 0) ? if1.TxD : if0.TxD;
    endfunction
    function automatic logic rdy(int s);
        return (s != 0) ? if1.Ready : if0.Ready;
    endfunction
    function automatic logic bsy(int s);
        return (s != 0) ? if1.Busy : if0.Busy;
    endfunction

    task automatic set_in(int s, logic ld, logic [DW-1:0] d);
        if (s != 0) begin
            if1.Load = ld;
            if1.Data = d;
        end else begin
            if0.Load = ld;
            if0.Data = d;
        end
    endtask

    task automatic idle_chk(int s, string tag);
        chk({tag, "_txd"},   txd(s), 1);
        chk({tag, "_ready"}, rdy(s), 1);
        chk({tag, "_busy"},  bsy(s), 0);
    endtask

    // Sends d on instance s; inj>0 disturbs frame cycle inj (1 = first start-bit cycle)
    // with either a Load of 8'hFF or a Clr pulse.
    task automatic frame(int s, logic [DW-1:0] d, logic [DW-1:0] after_d, bit hold,
                         int inj, bit inj_clr, string tag);
        int cyc = 0;
        bit e;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (s != 0) exp_q.push_back(^d);
        exp_q.push_back(1'b1);
        set_in(s, 1'b1, d);
        tick();
        set_in(s, hold, after_d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < BC; c++) begin
                cyc++;
                chk($sformatf("%s_txd_c%0d", tag, cyc), txd(s), e);
                if (c == 0) chk($sformatf("%s_ready_c%0d", tag, cyc), rdy(s), 0);
                if (c == 0) chk($sformatf("%s_busy_c%0d", tag, cyc), bsy(s), 1);
                if (cyc == inj && inj_clr) begin
                    Clr = 1'b1;
                    tick();
                    Clr = 1'b0;
                    idle_chk(s, {tag, "_abort"});
                    exp_q.delete();
                    return;
                end else if (cyc == inj) begin
                    set_in(s, 1'b1, 8'hFF);
                    tick();
                    set_in(s, 1'b0, after_d);
                end else begin
                    tick();
                end
            end
        end
        idle_chk(s, {tag, "_end"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Clr = 1'b1;
        set_in(0, 1'b0, '0);
        set_in(1, 1'b0, '0);
        tick();
        tick();
        idle_chk(0, "rst0");
        idle_chk(1, "rst1");
        Clr = 1'b0;
        tick();
        idle_chk(0, "post_rst0");

        // Single frame A5 (40-cycle frame), data changed after acceptance
        frame(0, 8'hA5, 8'h5A, 1'b0, 0, 1'b0, "a5");
        tick();

        // Parity frames: 07 has odd weight, A5 even
        frame(1, 8'h07, 8'hF8, 1'b0, 0, 1'b0, "par07");
        frame(1, 8'hA5, 8'h00, 1'b0, 0, 1'b0, "parA5");

        // Load during a frame is dropped, not queued
        frame(0, 8'h00, 8'h00, 1'b0, 10, 1'b0, "ign");
        for (int i = 0; i < 2 * BC; i++) begin
            tick();
            idle_chk(0, "ign_noq");
        end

        // Abort mid-frame, then load in the very next cycle
        frame(0, 8'hC3, 8'h00, 1'b0, 15, 1'b1, "clr");
        frame(0, 8'h3C, 8'hFF, 1'b0, 0, 1'b0, "after_clr");

        // Back-to-back with Load held high: one idle cycle between frames
        frame(0, 8'h55, 8'hAA, 1'b1, 0, 1'b0, "b2b1");
        frame(0, 8'hAA, 8'h00, 1'b0, 0, 1'b0, "b2b2");
        tick();
        idle_chk(0, "b2b_done");

        // Clr wins over Load in the same cycle
        Clr = 1'b1;
        set_in(0, 1'b1, 8'h55);
        tick();
        idle_chk(0, "prio");
        Clr = 1'b0;
        set_in(0, 1'b0, 8'h00);
        for (int i = 0; i < BC; i++) begin
            tick();
            idle_chk(0, "prio_nostart");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width in bits.
REQ-002 Parameter BIT_CYCLES, default 4, SHALL set the clock cycles per serial bit period; legal range 2..256.
REQ-003 Parameter PARITY_EN, default 0, SHALL insert an even-parity bit after the data bits when set to 1.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Clr  input  1  SHALL be the synchronous, active-high reset.
REQ-006 Data  input  DATA_W  SHALL be the parallel word to transmit, sampled only on acceptance.
REQ-007 Load  input  1  SHALL request transmission of Data.
REQ-008 Ready  output  1  SHALL indicate that the block can accept a word this cycle.
REQ-009 TxD  output  1  SHALL be the serial line, idle high, registered.
REQ-010 Busy  output  1  SHALL be high while a frame is on the line, and SHALL equal ~Ready.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-012 The block SHALL accept a word only when Load and Ready are both high at a rising edge; on acceptance it SHALL capture Data into a shift register and enter START.
REQ-013 TxD SHALL go low on the edge that accepts the word, so the start bit appears 1 cycle after Load is sampled.
REQ-014 Each bit (start, data, parity, stop) SHALL hold on TxD for exactly BIT_CYCLES cycles, timed by a bit counter that runs 0..BIT_CYCLES-1 and wraps.
REQ-015 DATA SHALL shift bits out LSB first, one bit per bit period, and SHALL track the count in a bit index of width $clog2(DATA_W+1).
REQ-016 After DATA_W bits, the FSM SHALL enter PARITY if PARITY_EN=1 and STOP otherwise.
REQ-017 The PARITY bit value SHALL be the XOR of all captured data bits.
REQ-018 STOP SHALL drive TxD=1 for one bit period, then return to IDLE.
REQ-019 Ready SHALL be 1 only in IDLE; Ready SHALL rise in the cycle after the final stop-bit cycle.
REQ-020 The total frame SHALL last (2+DATA_W+PARITY_EN)*BIT_CYCLES cycles from the start bit to the first cycle of IDLE.
REQ-021 Load asserted while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-022 Data changes after acceptance SHALL NOT affect the frame in flight.
REQ-023 Back-to-back frames SHALL be separated by at least 1 idle cycle with TxD=1.

Reset
REQ-024 When Clr=1 at a rising edge, the block SHALL set state=IDLE, TxD=1, Ready=1, Busy=0, and zero the bit counter, bit index and shift register.
REQ-025 Clr SHALL take priority over Load when both are asserted in the same cycle, and no word SHALL be accepted.
REQ-026 Clr asserted mid-frame SHALL abort the frame, with TxD=1 from the next edge.
REQ-027 After Clr deasserts, the block SHALL accept a Load in the first following cycle.

Structure
REQ-028 The state enum (IDLE, START, DATA, PARITY, STOP) and the TxD idle level constant SHALL live in the shared package serial_pkg, which the future receiver will reuse.
REQ-029 The bit-period counter SHALL be a separate sub-module named bit_timer, with CLK, Clr and enable inputs and a tick output that pulses on count BIT_CYCLES-1.
REQ-030 All outputs SHALL be driven directly from flops, with no combinational path from Load to TxD.

Verification
REQ-031 Single frame: with DATA_W=8, BIT_CYCLES=4, PARITY_EN=0, Data=8'hA5 and a 1-cycle Load, TxD SHALL show the bit sequence 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; Ready SHALL return to 1 after 40 cycles.
REQ-032 Parity frame: with PARITY_EN=1 and Data=8'h07, the parity bit SHALL be 1 and the frame SHALL last 44 cycles.
REQ-033 Ignored load: Load pulsed with Data=8'hFF in cycle 10 of an 8'h00 frame SHALL leave the frame unchanged, with all data bits 0 and no second frame sent.
REQ-034 Mid-frame reset: Clr pulsed in cycle 15 of a frame SHALL give TxD=1, Ready=1 on the next edge; a Load with 8'h3C in the next cycle SHALL send a correct full frame.
REQ-035 Back-to-back: Load held high continuously with Data=8'h55 then 8'hAA SHALL produce two correct frames separated by exactly 1 idle cycle.
REQ-036 Reset priority: Clr=1 and Load=1 in the same cycle SHALL leave TxD=1 and Ready=1 with no frame started.
